sram_arbiter: RTL and testbench

- Two-master arbiter that sits directly upstream of the on-chip SRAM/SDRAM-emulation memory block and drives its strobe/address/data bus.
- Port A is the CPU bus; port B is the DMA/disk-controller bus.
- Serialises requests with round-robin fairness and registers the command bus.
- Guarantees the mandatory strobe-low gap between transactions (the memory's ack pipeline re-arms only after strobe deasserts).
- Provides a watchdog that terminates a hung transaction with a bus error.

---
 rtl/sram_arbiter_if.sv | 49 ++++
 rtl/sram_arbiter.sv | 131 +++++++++++++
 tb/tb_sram_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the SRAM/SDRAM-emulation memory.
// The slave modport is the arbiter's view; the master modport is the environment's view.
`timescale 1ns/1ps
interface sram_arbiter_if;
    logic        a_stb;
    logic        a_we;
    logic [1:0]  a_sel;
    logic [21:1] a_adr;
    logic [15:0] a_dat_o;
    logic        a_ack;
    logic        a_err;
    logic [15:0] a_dat_i;

    logic        b_stb;
    logic        b_we;
    logic [1:0]  b_sel;
    logic [21:1] b_adr;
    logic [15:0] b_dat_o;
    logic        b_ack;
    logic        b_err;
    logic [15:0] b_dat_i;

    logic        mem_stb;
    logic        mem_we;
    logic [1:0]  mem_sel;
    logic [21:1] mem_adr;
    logic [15:0] mem_out;
    logic        mem_ack;
    logic [15:0] mem_dat;
    logic        mem_ready;

    modport slave (
        input  a_stb, a_we, a_sel, a_adr, a_dat_o,
        output a_ack, a_err, a_dat_i,
        input  b_stb, b_we, b_sel, b_adr, b_dat_o,
        output b_ack, b_err, b_dat_i,
        output mem_stb, mem_we, mem_sel, mem_adr, mem_out,
        input  mem_ack, mem_dat, mem_ready
    );

    modport master (
        output a_stb, a_we, a_sel, a_adr, a_dat_o,
        input  a_ack, a_err, a_dat_i,
        output b_stb, b_we, b_sel, b_adr, b_dat_o,
        input  b_ack, b_err, b_dat_i,
        input  mem_stb, mem_we, mem_sel, mem_adr, mem_out,
        output mem_ack, mem_dat, mem_ready
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin two-master arbiter driving a registered memory command bus, with a
// forced strobe-low recovery cycle between transactions and a hung-transaction watchdog.
`timescale 1ns/1ps
module sram_arbiter #(
    parameter int unsigned TO_W = 8
) (
    input  logic           clk_p,
    input  logic           reset_n,
    sram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_e;
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  sel;
        logic [21:1] adr;
        logic [15:0] dat;
    } cmd_t;

    localparam logic [TO_W-1:0] CNT_MAX = '1;

    state_e          state_q, state_d;
    port_e           gnt_q, gnt_d;
    port_e           last_q, last_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            stb_q, stb_d;
    cmd_t            cmd_q, cmd_d;

    cmd_t  cmd_a_c, cmd_b_c;
    logic  grant_en_c;
    port_e grant_port_c;
    logic  gnt_stb_c;
    logic  busy_c;
    logic  timeout_c;

    assign cmd_a_c = cmd_t'{we: bus.a_we, sel: bus.a_sel, adr: bus.a_adr, dat: bus.a_dat_o};
    assign cmd_b_c = cmd_t'{we: bus.b_we, sel: bus.b_sel, adr: bus.b_adr, dat: bus.b_dat_o};

    assign busy_c    = (state_q == BUSY);
    assign gnt_stb_c = (gnt_q == PORT_A) ? bus.a_stb : bus.b_stb;
    assign timeout_c = busy_c && (cnt_q == CNT_MAX) && !bus.mem_ack;

    // Round-robin pick: on a tie the port that did not win last time goes first
    always_comb begin
        grant_en_c   = 1'b0;
        grant_port_c = PORT_A;
        if (bus.mem_ready && !busy_c) begin
            if (bus.a_stb && bus.b_stb) begin
                grant_en_c   = 1'b1;
                grant_port_c = (last_q == PORT_B) ? PORT_A : PORT_B;
            end else if (bus.a_stb) begin
                grant_en_c   = 1'b1;
                grant_port_c = PORT_A;
            end else if (bus.b_stb) begin
                grant_en_c   = 1'b1;
                grant_port_c = PORT_B;
            end
        end
    end

    always_ff @(posedge clk_p or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= PORT_A;
            last_q  <= PORT_B;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        stb_d   = stb_q;
        cmd_d   = cmd_q;
        case (state_q)
            IDLE, RECOVER: begin
                if (grant_en_c) begin
                    state_d = BUSY;
                    gnt_d   = grant_port_c;
                    last_d  = grant_port_c;
                    cnt_d   = '0;
                    stb_d   = 1'b1;
                    cmd_d   = (grant_port_c == PORT_A) ? cmd_a_c : cmd_b_c;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // Completion, master abort and watchdog expiry all end in the strobe-low cycle
                if (bus.mem_ack || !gnt_stb_c || timeout_c) begin
                    state_d = RECOVER;
                    stb_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                stb_d   = 1'b0;
            end
        endcase
    end

    assign bus.mem_stb = stb_q;
    assign bus.mem_we  = cmd_q.we;
    assign bus.mem_sel = cmd_q.sel;
    assign bus.mem_adr = cmd_q.adr;
    assign bus.mem_out = cmd_q.dat;

    // Acks are combinational so the master sees them in the same cycle as mem_ack
    assign bus.a_ack   = busy_c && (gnt_q == PORT_A) && (bus.mem_ack || timeout_c);
    assign bus.b_ack   = busy_c && (gnt_q == PORT_B) && (bus.mem_ack || timeout_c);
    assign bus.a_err   = (gnt_q == PORT_A) && timeout_c;
    assign bus.b_err   = (gnt_q == PORT_B) && timeout_c;
    assign bus.a_dat_i = (gnt_q != PORT_A) ? 16'h0000 : (timeout_c ? 16'hFFFF : bus.mem_dat);
    assign bus.b_dat_i = (gnt_q != PORT_B) ? 16'h0000 : (timeout_c ? 16'hFFFF : bus.mem_dat);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: memory model acks two cycles after strobe rises,
// checks sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_sram_arbiter;

    logic clk_p;
    logic reset_n;
    logic mem_en;
    logic mcnt_q;
    int   checks;
    int   failures;

    localparam logic [21:1] ADR_A = 21'h00AAA;
    localparam logic [21:1] ADR_B = 21'h15555;

    sram_arbiter_if bus();

    sram_arbiter #(.TO_W(4)) dut (
        .clk_p  (clk_p),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk_p = 1'b0;
        forever #5 clk_p = ~clk_p;
    end

    // Memory emulation: mem_ack in the third cycle of a strobe, dropped after one cycle
    always @(posedge clk_p or negedge reset_n) begin
        if (!reset_n) begin
            bus.mem_ack <= 1'b0;
            mcnt_q      <= 1'b0;
        end else if (bus.mem_stb && mem_en && !bus.mem_ack) begin
            bus.mem_ack <= mcnt_q;
            mcnt_q      <= 1'b1;
        end else begin
            bus.mem_ack <= 1'b0;
            mcnt_q      <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        mem_en      = 1'b1;
        reset_n     = 1'b0;
        bus.a_stb   = 1'b0; bus.a_we = 1'b0; bus.a_sel = 2'b00; bus.a_adr = '0; bus.a_dat_o = '0;
        bus.b_stb   = 1'b0; bus.b_we = 1'b0; bus.b_sel = 2'b00; bus.b_adr = '0; bus.b_dat_o = '0;
        bus.mem_dat = 16'h0000;
        bus.mem_ready = 1'b1;

        tick();
        check("rst_mem_stb", 32'(bus.mem_stb), 32'd0);
        check("rst_mem_adr", 32'(bus.mem_adr), 32'd0);
        check("rst_mem_out", 32'(bus.mem_out), 32'd0);
        check("rst_a_ack",   32'(bus.a_ack),   32'd0);
        check("rst_b_err",   32'(bus.b_err),   32'd0);
        reset_n = 1'b1;
        tick();

        // Single read on port A
        bus.a_stb = 1'b1; bus.a_we = 1'b0; bus.a_sel = 2'b11; bus.a_adr = 21'h00100;
        bus.mem_dat = 16'h1234;
        check("rd_stb_pre", 32'(bus.mem_stb), 32'd0);
        tick();
        check("rd_stb_up",  32'(bus.mem_stb), 32'd1);
        check("rd_adr",     32'(bus.mem_adr), 32'h00100);
        check("rd_we",      32'(bus.mem_we),  32'd0);
        check("rd_ack_c1",  32'(bus.a_ack),   32'd0);
        tick();
        check("rd_ack_c2",  32'(bus.a_ack),   32'd0);
        tick();
        check("rd_ack",     32'(bus.a_ack),   32'd1);
        check("rd_err",     32'(bus.a_err),   32'd0);
        check("rd_dat",     32'(bus.a_dat_i), 32'h1234);
        check("rd_b_ack",   32'(bus.b_ack),   32'd0);
        bus.a_stb = 1'b0;
        tick();
        check("rd_recover_stb", 32'(bus.mem_stb), 32'd0);
        check("rd_ack_once",    32'(bus.a_ack),   32'd0);
        tick();
        check("rd_idle_stb",    32'(bus.mem_stb), 32'd0);

        // Single write on port B
        bus.b_stb = 1'b1; bus.b_we = 1'b1; bus.b_sel = 2'b10; bus.b_adr = 21'h08000;
        bus.b_dat_o = 16'hBEEF;
        tick();
        check("wr_stb", 32'(bus.mem_stb), 32'd1);
        check("wr_we",  32'(bus.mem_we),  32'd1);
        check("wr_sel", 32'(bus.mem_sel), 32'd2);
        check("wr_adr", 32'(bus.mem_adr), 32'h08000);
        check("wr_out", 32'(bus.mem_out), 32'hBEEF);
        tick();
        check("wr_ack_c2", 32'(bus.b_ack), 32'd0);
        tick();
        check("wr_ack",   32'(bus.b_ack), 32'd1);
        check("wr_a_ack", 32'(bus.a_ack), 32'd0);
        bus.b_stb = 1'b0;
        tick();
        check("wr_recover_stb", 32'(bus.mem_stb), 32'd0);
        check("wr_ack_once",    32'(bus.b_ack),   32'd0);
        tick();

        // Contention: both held, expect A,B,A,B with one low cycle each
        bus.a_adr = ADR_A; bus.b_adr = ADR_B; bus.b_we = 1'b0;
        bus.a_stb = 1'b1;  bus.b_stb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_stb", 32'(bus.mem_stb), 32'd1);
            check("rr_adr", 32'(bus.mem_adr), (k % 2 == 0) ? 32'(ADR_A) : 32'(ADR_B));
            tick();
            tick();
            check("rr_a_ack", 32'(bus.a_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_b_ack", 32'(bus.b_ack), (k % 2 == 0) ? 32'd0 : 32'd1);
            if (k == 3) begin
                bus.a_stb = 1'b0;
                bus.b_stb = 1'b0;
            end
            tick();
            check("rr_gap", 32'(bus.mem_stb), 32'd0);
        end
        tick();
        check("rr_idle", 32'(bus.mem_stb), 32'd0);

        // Watchdog: memory never acks, expiry on BUSY counter value 15
        mem_en = 1'b0;
        bus.a_stb = 1'b1;
        tick();
        check("to_stb", 32'(bus.mem_stb), 32'd1);
        for (int k = 0; k < 14; k++) tick();
        check("to_early_ack", 32'(bus.a_ack), 32'd0);
        check("to_early_stb", 32'(bus.mem_stb), 32'd1);
        tick();
        check("to_ack", 32'(bus.a_ack),   32'd1);
        check("to_err", 32'(bus.a_err),   32'd1);
        check("to_dat", 32'(bus.a_dat_i), 32'hFFFF);
        check("to_b_ack", 32'(bus.b_ack), 32'd0);
        bus.a_stb = 1'b0;
        bus.b_stb = 1'b1;
        bus.mem_dat = 16'h5A5A;
        mem_en = 1'b1;
        tick();
        check("to_recover_stb", 32'(bus.mem_stb), 32'd0);
        check("to_ack_once",    32'(bus.a_ack),   32'd0);
        tick();
        check("to_b_stb", 32'(bus.mem_stb), 32'd1);
        check("to_b_adr", 32'(bus.mem_adr), 32'(ADR_B));
        tick();
        tick();
        check("to_b_ack", 32'(bus.b_ack),   32'd1);
        check("to_b_err", 32'(bus.b_err),   32'd0);
        check("to_b_dat", 32'(bus.b_dat_i), 32'h5A5A);
        bus.b_stb = 1'b0;
        tick();
        check("to_b_gap", 32'(bus.mem_stb), 32'd0);
        tick();

        // Abort: A drops its strobe one cycle after grant
        bus.a_stb = 1'b1;
        tick();
        check("ab_stb", 32'(bus.mem_stb), 32'd1);
        bus.a_stb = 1'b0;
        tick();
        check("ab_recover", 32'(bus.mem_stb), 32'd0);
        check("ab_no_ack1", 32'(bus.a_ack),   32'd0);
        tick();
        check("ab_idle",    32'(bus.mem_stb), 32'd0);
        check("ab_no_ack2", 32'(bus.a_ack),   32'd0);

        // mem_ready low holds off the grant
        bus.mem_ready = 1'b0;
        bus.a_stb = 1'b1;
        tick();
        check("rdy_hold1", 32'(bus.mem_stb), 32'd0);
        tick();
        check("rdy_hold2", 32'(bus.mem_stb), 32'd0);
        bus.mem_ready = 1'b1;
        tick();
        check("rdy_grant", 32'(bus.mem_stb), 32'd1);
        tick();
        tick();
        check("rdy_ack", 32'(bus.a_ack), 32'd1);
        bus.a_stb = 1'b0;
        tick();
        check("rdy_gap", 32'(bus.mem_stb), 32'd0);
        tick();

        // Async reset mid-BUSY; last was A so B wins this tie
        bus.a_stb = 1'b1; bus.b_stb = 1'b1;
        tick();
        check("ar_stb", 32'(bus.mem_stb), 32'd1);
        check("ar_adr", 32'(bus.mem_adr), 32'(ADR_B));
        #3;
        reset_n = 1'b0;
        #1;
        check("ar_stb_drop", 32'(bus.mem_stb), 32'd0);
        check("ar_no_ack",   32'(bus.b_ack),   32'd0);
        reset_n = 1'b1;
        tick();
        check("ar_regrant_stb", 32'(bus.mem_stb), 32'd1);
        check("ar_regrant_adr", 32'(bus.mem_adr), 32'(ADR_A));
        tick();
        tick();
        check("ar_a_ack", 32'(bus.a_ack), 32'd1);
        check("ar_b_ack", 32'(bus.b_ack), 32'd0);
        bus.a_stb = 1'b0; bus.b_stb = 1'b0;
        tick();
        check("ar_gap", 32'(bus.mem_stb), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
